// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;
  localparam int   FIFO_DEPTH = 2;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t CNT_EMPTY = 2'd0;
  localparam fifo_cnt_t CNT_FULL  = 2'd2;

endpackage

// File: rtl/demux_stream_fifo2.sv
// Two-entry FIFO with registered head word and registered empty/full flags.
module fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_s [FIFO_DEPTH];
  logic             wr_ptr_r, wr_ptr_s;
  logic             rd_ptr_r, rd_ptr_s;
  fifo_cnt_t        count_r, count_s;
  logic [WIDTH-1:0] head_r, head_s;
  logic             empty_r, full_r;
  logic             do_push_s, do_pop_s;

  // Next-state: storage, pointers, count and the head word that follows them.
  always_comb begin
    do_push_s = push && !full_r;
    do_pop_s  = pop && !empty_r;
    mem_s     = mem_r;
    wr_ptr_s  = wr_ptr_r;
    rd_ptr_s  = rd_ptr_r;
    count_s   = count_r;
    head_s    = head_r;
    case ({do_push_s, do_pop_s})
      2'b10: begin
        mem_s[wr_ptr_r] = push_data;
        wr_ptr_s        = ~wr_ptr_r;
        count_s         = count_r + 2'd1;
        if (empty_r) begin
          head_s = push_data;
        end else begin
          head_s = head_r;
        end
      end
      2'b01: begin
        rd_ptr_s = ~rd_ptr_r;
        count_s  = count_r - 2'd1;
        // Only a full FIFO has a second entry to promote into the head.
        if (full_r) begin
          head_s = mem_r[~rd_ptr_r];
        end else begin
          head_s = head_r;
        end
      end
      2'b11: begin
        // Both allowed only at count 1: the new word becomes the head.
        mem_s[wr_ptr_r] = push_data;
        wr_ptr_s        = ~wr_ptr_r;
        rd_ptr_s        = ~rd_ptr_r;
        head_s          = push_data;
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // State registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= CNT_EMPTY;
      head_r   <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      mem_r    <= mem_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      head_r   <= head_s;
      empty_r  <= (count_s == CNT_EMPTY);
      full_r   <= (count_s == CNT_FULL);
    end
  end

  assign head_data = head_r;
  assign empty     = empty_r;
  assign full      = full_r;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demultiplexer: each destination has its own 2-entry FIFO.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready
);

  logic             full1_s, full2_s;
  logic             empty1_s, empty2_s;
  logic [WIDTH-1:0] head1_s, head2_s;
  logic             sel_full_s, accept_s;
  logic             push1_s, push2_s, pop1_s, pop2_s;

  // Select decode and handshake glue; in_ready never looks at the consumers.
  always_comb begin
    case (in_sel)
      SEL_OUT1: sel_full_s = full1_s;
      SEL_OUT2: sel_full_s = full2_s;
      default:  sel_full_s = 1'b1;
    endcase
    in_ready = !rst && !sel_full_s;
    accept_s = in_valid && in_ready;
    push1_s  = accept_s && (in_sel == SEL_OUT1);
    push2_s  = accept_s && (in_sel == SEL_OUT2);
    pop1_s   = !empty1_s && out1_ready;
    pop2_s   = !empty2_s && out2_ready;
  end

  fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1_s),
    .push_data (in_data),
    .pop       (pop1_s),
    .head_data (head1_s),
    .empty     (empty1_s),
    .full      (full1_s)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push2_s),
    .push_data (in_data),
    .pop       (pop2_s),
    .head_data (head2_s),
    .empty     (empty2_s),
    .full      (full2_s)
  );

  assign out1_data  = head1_s;
  assign out1_valid = !empty1_s;
  assign out2_data  = head2_s;
  assign out2_valid = !empty2_s;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed vector table, count-1 streaming and a queue-model random run.
module tb_demux_stream;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  demux_stream #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       sel;
    logic       r1;
    logic       r2;
    logic       e_ir;
    logic       e_v1;
    logic [7:0] e_d1;
    logic       e_v2;
    logic [7:0] e_d2;
    logic       chk_zero;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d, input logic sel,
                              input logic r1, input logic r2, input logic e_ir,
                              input logic e_v1, input logic [7:0] e_d1,
                              input logic e_v2, input logic [7:0] e_d2, input logic chk_zero);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.sel = sel; v.r1 = r1; v.r2 = r2;
    v.e_ir = e_ir; v.e_v1 = e_v1; v.e_d1 = e_d1; v.e_v2 = e_v2; v.e_d2 = e_d2;
    v.chk_zero = chk_zero;
    return v;
  endfunction

  task automatic chk_bit(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;

    //            rst   iv    d      sel   r1    r2    ir    v1    d1     v2    d2     zero
    vecs[0]  = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    vecs[1]  = mk(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    vecs[2]  = mk(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 8'h44, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    vecs[17] = mk(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].d; in_sel = vecs[i].sel;
      out1_ready = vecs[i].r1; out2_ready = vecs[i].r2;
      #1;
      n_vec++;
      chk_bit("in_ready", i, in_ready, vecs[i].e_ir);
      chk_bit("out1_valid", i, out1_valid, vecs[i].e_v1);
      chk_bit("out2_valid", i, out2_valid, vecs[i].e_v2);
      if (vecs[i].e_v1 || vecs[i].chk_zero) chk_byte("out1_data", i, out1_data, vecs[i].e_d1);
      if (vecs[i].e_v2 || vecs[i].chk_zero) chk_byte("out2_data", i, out2_data, vecs[i].e_d2);
    end

    // Back-to-back words through out1 with its consumer always ready: count stays at 1.
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      rst = 1'b0; in_valid = (i < 10); in_data = 8'(i + 1); in_sel = 1'b0;
      out1_ready = 1'b1; out2_ready = 1'b1;
      #1;
      n_vec++;
      chk_bit("stream_in_ready", i, in_ready, 1'b1);
      chk_bit("stream_out1_valid", i, out1_valid, (i > 0));
      if (i > 0) chk_byte("stream_out1_data", i, out1_data, 8'(i));
      chk_bit("stream_out2_valid", i, out2_valid, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    chk_bit("stream_drained", 0, out1_valid, 1'b0);

    // Random traffic against two reference queues.
    for (int c = 0; c < 1000; c++) begin
      logic e_ir, e_v1, e_v2;
      @(negedge clk);
      in_data    = 8'($urandom_range(0, 255));
      in_sel     = 1'($urandom_range(0, 1));
      in_valid   = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      out2_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_vec++;
      e_ir = in_sel ? (q2.size() < 2) : (q1.size() < 2);
      e_v1 = (q1.size() != 0);
      e_v2 = (q2.size() != 0);
      chk_bit("rnd_in_ready", c, in_ready, e_ir);
      chk_bit("rnd_out1_valid", c, out1_valid, e_v1);
      chk_bit("rnd_out2_valid", c, out2_valid, e_v2);
      if (e_v1) chk_byte("rnd_out1_data", c, out1_data, q1[0]);
      if (e_v2) chk_byte("rnd_out2_data", c, out2_data, q2[0]);
      if (e_v1 && out1_ready) void'(q1.pop_front());
      if (e_v2 && out2_ready) void'(q2.pop_front());
      if (in_valid && e_ir) begin
        if (in_sel) q2.push_back(in_data);
        else        q1.push_back(in_data);
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
